sync_fifo_fwft: RTL and testbench

//  Single-clock, parametrised FIFO for 66-bit PCS block buffering between RX stages

---
 rtl/sync_fifo_fwft.sv | 107 ++++++++++
 tb/tb_sync_fifo_fwft.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through, occupancy level,
// almost-full/empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_fwft #(
    parameter int DSIZE     = 66,
    parameter int ASIZE     = 3,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             clr_err,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             almost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             almost_empty,
    output logic [ASIZE:0]   level,
    output logic             overflow,
    output logic             underflow
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_L    = (ASIZE+1)'(AF_THRESH);
    localparam logic [ASIZE:0] AE_L    = (ASIZE+1)'(AE_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_fwft: AF_THRESH out of range");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_fwft: AE_THRESH out of range");
    end

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr, rptr, level_nxt;
    logic [ASIZE-1:0] waddr, raddr;
    logic [DSIZE-1:0] rdata_q;
    logic             wr_ok, rd_ok;

    assign waddr = wptr[ASIZE-1:0];
    assign raddr = rptr[ASIZE-1:0];
    // Acceptance uses registered flags, so a full FIFO never passes a write through.
    assign wr_ok = winc && !wfull  && !flush;
    assign rd_ok = rinc && !rempty && !flush;

    always_comb begin
        level_nxt = level + {{ASIZE{1'b0}}, wr_ok} - {{ASIZE{1'b0}}, rd_ok};
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            wfull        <= 1'b0;
            rempty       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            if (flush) begin
                wptr         <= '0;
                rptr         <= '0;
                level        <= '0;
                wfull        <= 1'b0;
                rempty       <= 1'b1;
                almost_full  <= 1'b0;
                almost_empty <= 1'b1;
            end else begin
                if (wr_ok) wptr <= wptr + 1'b1;
                if (rd_ok) rptr <= rptr + 1'b1;
                level        <= level_nxt;
                wfull        <= (level_nxt == DEPTH_L);
                rempty       <= (level_nxt == '0);
                almost_full  <= (level_nxt >= AF_L);
                almost_empty <= (level_nxt <= AE_L);
            end

            // A fresh error event outranks a simultaneous clear.
            if (winc && wfull && !flush)       overflow <= 1'b1;
            else if (clr_err)                  overflow <= 1'b0;
            if (rinc && rempty && !flush)      underflow <= 1'b1;
            else if (clr_err)                  underflow <= 1'b0;

            // FWFT tracks the head so rdata stays on the last head once empty.
            if (FWFT != 0) begin
                if (!rempty) rdata_q <= mem[raddr];
            end else begin
                if (rd_ok) rdata_q <= mem[raddr];
            end
        end
    end

    assign rdata = (FWFT != 0 && !rempty) ? mem[raddr] : rdata_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft: one FWFT instance for the main sequence,
// one registered-read instance for the FWFT=0 latency check.
module tb_sync_fifo_fwft;

    logic        clk = 1'b0;
    logic        rst_n, flush, clr_err, winc, rinc;
    logic [65:0] wdata, rdata;
    logic        wfull, almost_full, rempty, almost_empty, overflow, underflow;
    logic [3:0]  level;

    logic        b_rst_n, b_flush, b_clr_err, b_winc, b_rinc;
    logic [65:0] b_wdata, b_rdata;
    logic        b_wfull, b_almost_full, b_rempty, b_almost_empty, b_overflow, b_underflow;
    logic [3:0]  b_level;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DSIZE(66), .ASIZE(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
        .winc(winc), .wdata(wdata), .wfull(wfull), .almost_full(almost_full),
        .rinc(rinc), .rdata(rdata), .rempty(rempty), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_fwft #(.DSIZE(66), .ASIZE(3), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) dut_reg (
        .clk(clk), .rst_n(b_rst_n), .flush(b_flush), .clr_err(b_clr_err),
        .winc(b_winc), .wdata(b_wdata), .wfull(b_wfull), .almost_full(b_almost_full),
        .rinc(b_rinc), .rdata(b_rdata), .rempty(b_rempty), .almost_empty(b_almost_empty),
        .level(b_level), .overflow(b_overflow), .underflow(b_underflow)
    );

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_level"},  66'(level), 66'd0);
        chk({tag, "_rempty"}, 66'(rempty), 66'd1);
        chk({tag, "_wfull"},  66'(wfull), 66'd0);
        chk({tag, "_af"},     66'(almost_full), 66'd0);
        chk({tag, "_ae"},     66'(almost_empty), 66'd1);
        chk({tag, "_ovf"},    66'(overflow), 66'd0);
        chk({tag, "_udf"},    66'(underflow), 66'd0);
        chk({tag, "_rdata"},  rdata, 66'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
        b_rst_n = 1'b0; b_flush = 1'b0; b_clr_err = 1'b0; b_winc = 1'b0; b_rinc = 1'b0; b_wdata = '0;
        tick();
        chk_reset_state("reset");
        chk("b_reset_rdata", b_rdata, 66'd0);
        chk("b_reset_rempty", 66'(b_rempty), 66'd1);
        rst_n = 1'b1; b_rst_n = 1'b1;

        // Fill to full with 1..8
        for (int i = 1; i <= 8; i++) begin
            winc = 1'b1; wdata = 66'(i);
            tick();
            chk($sformatf("fill%0d_level", i), 66'(level), 66'(i));
            chk($sformatf("fill%0d_af", i), 66'(almost_full), 66'(i >= 6));
            chk($sformatf("fill%0d_ae", i), 66'(almost_empty), 66'(i <= 1));
            chk($sformatf("fill%0d_wfull", i), 66'(wfull), 66'(i == 8));
            chk($sformatf("fill%0d_rempty", i), 66'(rempty), 66'd0);
            chk($sformatf("fill%0d_head", i), rdata, 66'd1);
        end

        // Write while full is dropped
        wdata = 66'h9;
        tick();
        winc = 1'b0;
        chk("ovf_flag", 66'(overflow), 66'd1);
        chk("ovf_level", 66'(level), 66'd8);

        // Drain; FWFT head visible before each pop
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain%0d_head", i), rdata, 66'(i));
            rinc = 1'b1;
            tick();
            chk($sformatf("drain%0d_level", i), 66'(level), 66'(8 - i));
        end
        rinc = 1'b0;
        chk("drain_rempty", 66'(rempty), 66'd1);
        chk("drain_wfull", 66'(wfull), 66'd0);
        chk("drain_rdata_hold", rdata, 66'd8);

        // Read while empty
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        chk("udf_flag", 66'(underflow), 66'd1);
        chk("udf_rdata", rdata, 66'd8);
        chk("udf_level", 66'(level), 66'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_udf", 66'(underflow), 66'd0);
        chk("clr_ovf", 66'(overflow), 66'd0);

        // Level 4 then 20 cycles of simultaneous write/read across the wrap
        for (int i = 0; i < 4; i++) begin
            winc = 1'b1; wdata = 66'(8'h11 + i);
            tick();
        end
        chk("l4_level", 66'(level), 66'd4);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("steady%0d_head", k), rdata, 66'(8'h11 + k));
            winc = 1'b1; rinc = 1'b1; wdata = 66'(8'h15 + k);
            tick();
            chk($sformatf("steady%0d_level", k), 66'(level), 66'd4);
        end
        rinc = 1'b0;
        chk("steady_head_after", rdata, 66'h25);

        // Level 5, then flush with a concurrent write
        wdata = 66'h29;
        tick();
        chk("pre_flush_level", 66'(level), 66'd5);
        winc = 1'b1; flush = 1'b1; wdata = 66'h55;
        tick();
        winc = 1'b0; flush = 1'b0;
        chk("flush_level", 66'(level), 66'd0);
        chk("flush_rempty", 66'(rempty), 66'd1);
        chk("flush_ae", 66'(almost_empty), 66'd1);
        chk("flush_wfull", 66'(wfull), 66'd0);
        winc = 1'b1; wdata = 66'h77;
        tick();
        winc = 1'b0;
        chk("post_flush_level", 66'(level), 66'd1);
        chk("post_flush_head", rdata, 66'h77);

        // Reset in the middle of traffic at level 5
        for (int i = 0; i < 4; i++) begin
            winc = 1'b1; wdata = 66'(8'h80 + i);
            tick();
        end
        chk("pre_rst_level", 66'(level), 66'd5);
        rst_n = 1'b0; winc = 1'b1; rinc = 1'b1;
        tick();
        winc = 1'b0; rinc = 1'b0;
        chk_reset_state("midrst");
        rst_n = 1'b1;

        // Registered-read instance: data appears one cycle after the accepted read
        b_winc = 1'b1; b_wdata = 66'hA;
        tick();
        b_winc = 1'b0;
        chk("b_wr_rempty", 66'(b_rempty), 66'd0);
        chk("b_wr_rdata", b_rdata, 66'd0);
        b_rinc = 1'b1;
        tick();
        chk("b_rd_rdata", b_rdata, 66'hA);
        chk("b_rd_rempty", 66'(b_rempty), 66'd1);
        tick();
        b_rinc = 1'b0;
        chk("b_udf_flag", 66'(b_underflow), 66'd1);
        chk("b_udf_rdata", b_rdata, 66'hA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
